// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one single-port framebuffer RAM between VGA scan-out reads
// (iPixEn=1 slots) and pixel-writer / clear-engine writes (iPixEn=0 slots), and
// expands the RGB332 read data to 10-bit VGA colour.
module fb_arbiter #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int ADDR_W = 15
) (
  input  logic              CLOCK_50,
  input  logic              nRst,
  input  logic              iPixEn,
  input  logic [9:0]        iX,
  input  logic [9:0]        iY,
  input  logic              iImValid,
  output logic [9:0]        oRed,
  output logic [9:0]        oGreen,
  output logic [9:0]        oBlue,
  input  logic              iWrReq,
  input  logic [7:0]        iWrX,
  input  logic [6:0]        iWrY,
  input  logic [7:0]        iWrData,
  output logic              oWrAck,
  output logic              oWrErr,
  input  logic              iClear,
  input  logic [7:0]        iClearColor,
  output logic              oBusy,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic              oRamWe,
  output logic [7:0]        oRamWData,
  input  logic [7:0]        iRamRData
);

  localparam int FB_N = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_N - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, cnt_nxt;
  logic [7:0]        clr_color, color_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              we_nxt, ack_nxt, err_nxt;
  logic [7:0]        wdata_nxt;
  logic [ADDR_W-1:0] scan_addr, wr_addr;
  logic              wr_in_range;
  logic              vld_p1, vld_p2;
  logic              unused_lsbs;

  // Row-major address; the default 160-wide buffer uses row*128 + row*32.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] col, input logic [9:0] row);
    logic [19:0] r20, c20, sum;
    r20 = {10'd0, row};
    c20 = {10'd0, col};
    if (FB_W == 160) sum = (r20 << 7) + (r20 << 5) + c20;
    else             sum = r20 * 20'(FB_W) + c20;
    return ADDR_W'(sum);
  endfunction

  // 3-bit channel to 10 bits by bit replication.
  function automatic logic [9:0] expand3(input logic [2:0] c);
    return {c, c, c, c[2]};
  endfunction

  // 2-bit channel to 10 bits by bit replication.
  function automatic logic [9:0] expand2(input logic [1:0] c);
    return {c, c, c, c, c};
  endfunction

  // Scan reads are 4x replicated, so the two pixel LSBs never address the RAM.
  assign unused_lsbs = ^{iX[1:0], iY[1:0]};
  assign scan_addr   = pix_addr({2'd0, iX[9:2]}, {2'd0, iY[9:2]});
  assign wr_addr     = pix_addr({2'd0, iWrX}, {3'd0, iWrY});
  assign wr_in_range = ({24'd0, iWrX} < 32'(FB_W)) && ({25'd0, iWrY} < 32'(FB_H));
  assign oBusy       = (state == CLEAR);

  // State register.
  always_ff @(posedge CLOCK_50 or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: clear starts from any IDLE cycle and ends on the last fill write.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (iClear) state_nxt = CLEAR;
      CLEAR: if (!iPixEn && (clr_cnt == LAST_ADDR)) state_nxt = IDLE;
    endcase
  end

  // Slot decode: scan read, clear-engine write, or writer request (clear has priority).
  always_comb begin
    addr_nxt  = oRamAddr;
    we_nxt    = 1'b0;
    wdata_nxt = oRamWData;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    cnt_nxt   = clr_cnt;
    color_nxt = clr_color;
    if (iPixEn) begin
      addr_nxt = scan_addr;
    end else if (state == CLEAR) begin
      addr_nxt  = clr_cnt;
      we_nxt    = 1'b1;
      wdata_nxt = clr_color;
      cnt_nxt   = clr_cnt + ADDR_W'(1);
    end else if (iWrReq && !iClear) begin
      ack_nxt = 1'b1;
      if (wr_in_range) begin
        addr_nxt  = wr_addr;
        we_nxt    = 1'b1;
        wdata_nxt = iWrData;
      end else begin
        err_nxt = 1'b1;
      end
    end
    if ((state == IDLE) && iClear) begin
      color_nxt = iClearColor;
      cnt_nxt   = '0;
    end
  end

  // RAM port, handshake pulses and clear-engine registers.
  always_ff @(posedge CLOCK_50 or negedge nRst) begin
    if (!nRst) begin
      oRamAddr  <= '0;
      oRamWe    <= 1'b0;
      oRamWData <= '0;
      oWrAck    <= 1'b0;
      oWrErr    <= 1'b0;
      clr_cnt   <= '0;
      clr_color <= '0;
    end else begin
      oRamAddr  <= addr_nxt;
      oRamWe    <= we_nxt;
      oRamWData <= wdata_nxt;
      oWrAck    <= ack_nxt;
      oWrErr    <= err_nxt;
      clr_cnt   <= cnt_nxt;
      clr_color <= color_nxt;
    end
  end

  // p1/p2: active-area flag follows the address and RAM stages; colour loads on scan edges.
  always_ff @(posedge CLOCK_50 or negedge nRst) begin
    if (!nRst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
    end else begin
      vld_p1 <= iImValid;
      vld_p2 <= vld_p1;
      if (iPixEn) begin
        oRed   <= vld_p2 ? expand3(iRamRData[7:5]) : '0;
        oGreen <= vld_p2 ? expand3(iRamRData[4:2]) : '0;
        oBlue  <= vld_p2 ? expand2(iRamRData[1:0]) : '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: randomized and directed bench for fb_arbiter with a RAM model
// and a slot-level reference model of the arbiter behaviour.
module tb_fb_arbiter;

  localparam int FB_W   = 160;
  localparam int FB_H   = 120;
  localparam int ADDR_W = 15;
  localparam int FB_N   = FB_W * FB_H;
  localparam int RAM_N  = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, pix_en, im_valid, wr_req, clear;
  logic [9:0]        px, py;
  logic [7:0]        wr_x, wr_data, clear_color;
  logic [6:0]        wr_y;
  logic [9:0]        red, green, blue;
  logic              wr_ack, wr_err, busy, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata, ram_rdata;

  fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W)) dut (
    .CLOCK_50(clk), .nRst(rst_n), .iPixEn(pix_en), .iX(px), .iY(py),
    .iImValid(im_valid), .oRed(red), .oGreen(green), .oBlue(blue),
    .iWrReq(wr_req), .iWrX(wr_x), .iWrY(wr_y), .iWrData(wr_data),
    .oWrAck(wr_ack), .oWrErr(wr_err), .iClear(clear), .iClearColor(clear_color),
    .oBusy(busy), .oRamAddr(ram_addr), .oRamWe(ram_we), .oRamWData(ram_wdata),
    .iRamRData(ram_rdata)
  );

  function automatic logic [7:0] ram_fill(input int i);
    int v;
    v = (i == 0) ? 227 : i * 37 + 5;
    return v[7:0];
  endfunction

  // Single-port synchronous RAM, preloaded on the first clock edge.
  logic [7:0] ram [0:RAM_N-1];
  bit         ram_loaded;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < RAM_N; i++) ram[i] <= (i < FB_N) ? ram_fill(i) : 8'h00;
      ram_loaded <= 1'b1;
    end else begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] ref_mem [0:FB_N-1];
  bit         m_busy;
  int         m_idx;
  logic [7:0] m_col;
  bit         h1_v, h2_v;
  logic [7:0] h1_d, h2_d;
  logic [9:0] e_r, e_g, e_b;
  bit         rand_scan;

  function automatic logic [9:0] exp_rg(input logic [2:0] c);
    int v;
    v = (int'(c) * 1023 + 3) / 7;
    return v[9:0];
  endfunction

  function automatic logic [9:0] exp_b(input logic [1:0] c);
    int v;
    v = int'(c) * 341;
    return v[9:0];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_idx = 0;
    h1_v = 0; h2_v = 0; h1_d = 0; h2_d = 0;
    e_r = 0; e_g = 0; e_b = 0;
  endtask

  task automatic model_step();
    bit e_we, e_ack, e_err;
    int e_addr;
    logic [7:0] e_wd;
    if (!rst_n) begin
      model_reset();
      check("reset_outs", 64'({red, green, blue, ram_addr, ram_we, ram_wdata, wr_ack, wr_err, busy}), 64'(0));
      return;
    end
    e_we = 0; e_ack = 0; e_err = 0; e_addr = 0; e_wd = 0;
    if (pix_en) begin
      e_addr = (int'(py) / 4) * FB_W + int'(px) / 4;
      if (h2_v) begin
        e_r = exp_rg(h2_d[7:5]); e_g = exp_rg(h2_d[4:2]); e_b = exp_b(h2_d[1:0]);
      end else begin
        e_r = 0; e_g = 0; e_b = 0;
      end
      h2_v = h1_v; h2_d = h1_d; h1_v = im_valid; h1_d = ref_mem[e_addr];
      if (!m_busy && clear) begin m_busy = 1; m_idx = 0; m_col = clear_color; end
    end else begin
      h2_v = h1_v; h2_d = h1_d; h1_v = im_valid; h1_d = 0;
      if (m_busy) begin
        e_we = 1; e_addr = m_idx; e_wd = m_col;
        ref_mem[m_idx] = m_col;
        m_idx++;
        if (m_idx == FB_N) m_busy = 0;
      end else if (clear) begin
        m_busy = 1; m_idx = 0; m_col = clear_color;
      end else if (wr_req) begin
        e_ack = 1;
        if (int'(wr_x) < FB_W && int'(wr_y) < FB_H) begin
          e_we = 1; e_addr = int'(wr_y) * FB_W + int'(wr_x); e_wd = wr_data;
          ref_mem[e_addr] = wr_data;
        end else begin
          e_err = 1;
        end
      end
    end
    check("ram_we", 64'(ram_we), 64'(e_we));
    check("wr_ack", 64'(wr_ack), 64'(e_ack));
    check("wr_err", 64'(wr_err), 64'(e_err));
    check("busy", 64'(busy), 64'(m_busy));
    check("colour", 64'({red, green, blue}), 64'({e_r, e_g, e_b}));
    if (pix_en || e_we) check("ram_addr", 64'(ram_addr), 64'(e_addr));
    if (e_we) check("ram_wdata", 64'(ram_wdata), 64'(e_wd));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    pix_en = ~pix_en;
    clear = 1'b0;
    if (wr_ack) wr_req = 1'b0;
    if (rand_scan) begin
      px = 10'($urandom_range(0, 639));
      py = 10'($urandom_range(0, 479));
      im_valid = 1'($urandom_range(0, 1));
    end
  endtask

  // Make the next clock edge a scan (1) or writer (0) slot.
  task automatic align(input bit want_scan);
    if (pix_en != want_scan) cycle();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs", 64'({red, green, blue, ram_addr, ram_we, ram_wdata, wr_ack, wr_err, busy}), 64'(0));
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int lat, guard, busy_cnt, bad;
    rst_n = 1'b0; pix_en = 1'b1; px = '0; py = '0; im_valid = 1'b0;
    wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0; clear = 1'b0; clear_color = '0;
    rand_scan = 0;
    for (int i = 0; i < FB_N; i++) ref_mem[i] = ram_fill(i);
    model_reset();
    repeat (4) cycle();
    rst_n = 1'b1;

    align(0);
    cycle();
    check("first_wr_slot_we", 64'(ram_we), 64'(0));

    // Scan expansion of 0xE3 at address 0
    align(1);
    px = 10'd3; py = 10'd2; im_valid = 1'b1;
    cycle(); cycle(); cycle();
    check("scan_red", 64'(red), 64'(10'h3FF));
    check("scan_green", 64'(green), 64'(0));
    check("scan_blue", 64'(blue), 64'(10'h3FF));

    // Blanking
    align(1);
    im_valid = 1'b0;
    cycle(); cycle(); cycle();
    check("blank_rgb", 64'({red, green, blue}), 64'(0));

    // Writer handshake at the last pixel
    wr_req = 1'b1; wr_x = 8'd159; wr_y = 7'd119; wr_data = 8'h1C;
    lat = 0;
    while (!wr_ack && lat < 4) begin cycle(); lat++; end
    check("wr_ack_seen", 64'(wr_ack), 64'(1));
    check("wr_ack_latency_ok", 64'(lat <= 2), 64'(1));
    check("wr_addr", 64'(ram_addr), 64'(19199));
    check("wr_we", 64'(ram_we), 64'(1));
    check("wr_data", 64'(ram_wdata), 64'(8'h1C));
    check("wr_no_err", 64'(wr_err), 64'(0));
    cycle();
    check("wr_ack_one_cycle", 64'(wr_ack), 64'(0));
    check("ram_written", 64'(ram[19199]), 64'(8'h1C));

    // Out-of-range write
    wr_req = 1'b1; wr_x = 8'd160; wr_y = 7'd5; wr_data = 8'h77;
    lat = 0;
    while (!wr_ack && lat < 4) begin cycle(); lat++; end
    check("oor_ack", 64'(wr_ack), 64'(1));
    check("oor_err", 64'(wr_err), 64'(1));
    check("oor_no_write", 64'(ram_we), 64'(0));
    cycle();
    check("oor_err_pulse", 64'(wr_err), 64'(0));

    // Random traffic
    rand_scan = 1;
    for (int n = 0; n < 3000; n++) begin
      if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_req = 1'b1;
        wr_x = 8'($urandom_range(0, 175));
        wr_y = 7'($urandom_range(0, 127));
        wr_data = 8'($urandom);
      end
      cycle();
    end
    async_reset();
    wr_req = 1'b0;

    // Full clear with a pending request and a mid-fill iClear
    align(0);
    wr_req = 1'b1; wr_x = 8'd10; wr_y = 7'd10; wr_data = 8'hAA;
    clear = 1'b1; clear_color = 8'h55;
    cycle();
    check("clear_start_busy", 64'(busy), 64'(1));
    check("clear_wins_no_ack", 64'(wr_ack), 64'(0));
    busy_cnt = 1; guard = 0;
    while (busy && guard < 40000) begin
      if (guard == 5000) begin clear = 1'b1; clear_color = 8'h0F; end
      cycle();
      guard++;
      if (busy) busy_cnt++;
    end
    check("clear_busy_cycles", 64'(busy_cnt), 64'(2 * FB_N));
    lat = 0;
    while (!wr_ack && lat < 6) begin cycle(); lat++; end
    check("post_clear_ack_slot", 64'(lat), 64'(2));
    bad = 0;
    for (int i = 0; i < FB_N; i++) if (ram[i] !== 8'h55) bad++;
    check("clear_fill_bad_count", 64'(bad), 64'(0));
    cycle();

    // Reset in the middle of a clear, then restart
    wr_req = 1'b0;
    align(0);
    clear = 1'b1; clear_color = 8'h33;
    cycle();
    guard = 0;
    while (m_idx < 1000 && guard < 3000) begin cycle(); guard++; end
    check("mid_clear_addr", 64'(ram_addr), 64'(999));
    async_reset();
    check("mid_clear_busy_low", 64'(busy), 64'(0));
    align(0);
    clear = 1'b1; clear_color = 8'h99;
    cycle();
    lat = 0;
    while (!ram_we && lat < 4) begin cycle(); lat++; end
    check("restart_we", 64'(ram_we), 64'(1));
    check("restart_addr", 64'(ram_addr), 64'(0));
    check("restart_data", 64'(ram_wdata), 64'(8'h99));
    repeat (20) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Framebuffer arbiter and sequencer between the VGA scan-out path and a pixel writer. It time-shares one single-port synchronous RAM holding a 160x120 RGB332 framebuffer. Even slots serve scan-out reads that feed `vga_640x480` colour inputs at 4x pixel replication; odd slots serve writer requests and a built-in clear engine. The block sits in the 50 MHz domain beside the 25 MHz VGA controller.

## Interface
- `FB_W`, default 160: framebuffer width in pixels.
- `FB_H`, default 120: framebuffer height in pixels.
- `ADDR_W`, default 15: RAM address width; `FB_W*FB_H` must be ≤ 2^ADDR_W.

Ports:
- `CLOCK_50`  in  1: system clock; all logic on the rising edge.
- `nRst`  in  1: asynchronous, active-low reset.
- `iPixEn`  in  1: slot select. 1 = scan slot, 0 = writer slot. Alternates every cycle and is in phase with `CLOCK_25`.
- `iX`  in  10: VGA pixel x, 0..639.
- `iY`  in  10: VGA pixel y, 0..479.
- `iImValid`  in  1: VGA active-area flag.
- `oRed`, `oGreen`, `oBlue`  out  10 each: colour to the VGA controller `iRed`/`iGreen`/`iBlue`.
- `iWrReq`  in  1: writer request; held until ack.
- `iWrX`  in  8: writer x.
- `iWrY`  in  7: writer y.
- `iWrData`  in  8: RGB332 pixel, {R[2:0],G[2:0],B[1:0]}.
- `oWrAck`  out  1: one-cycle pulse when the request is consumed.
- `oWrErr`  out  1: one-cycle pulse with `oWrAck` when the request was out of range.
- `iClear`  in  1: start a full-buffer fill.
- `iClearColor`  in  8: fill colour, sampled at start.
- `oBusy`  out  1: clear in progress.
- `oRamAddr`  out  ADDR_W: registered RAM address.
- `oRamWe`  out  1: registered write enable.
- `oRamWData`  out  8: registered write data.
- `iRamRData`  in  8: RAM read data, valid 1 cycle after the address edge.

## Operation
- Address mapping: addr = row*FB_W + col, computed with shifts and adds (row*128 + row*32), no multiplier.
- Scan addressing: col = iX>>2, row = iY>>2.
- Writer addressing: col = iWrX, row = iWrY.
- State machine has two states, IDLE and CLEAR.
- Scan slot (`iPixEn`=1), any state:
  - oRamAddr ← scan address, oRamWe ← 0.
  - The `iImValid` value is delayed 2 cycles to gate colour.
- Writer slot (`iPixEn`=0), IDLE, `iWrReq`=1:
  - In range (iWrX<FB_W and iWrY<FB_H): oRamAddr ← addr, oRamWe ← 1, oRamWData ← iWrData, oWrAck ← 1.
  - Out of range: oRamWe ← 0, oWrAck ← 1, oWrErr ← 1.
- Writer slot, IDLE, no request: oRamWe ← 0.
- IDLE → CLEAR on `iClear`=1 in any cycle:
  - Latch iClearColor.
  - Clear counter ← 0.
  - oBusy ← 1 on the same edge.
- Writer slot in CLEAR:
  - Write the latched colour at the counter value, then increment the counter.
  - The write at address FB_W*FB_H−1 returns the state to IDLE with oBusy ← 0 on that edge.
  - `iWrReq` is not acked during CLEAR; the request waits.
- `iClear` while in CLEAR is ignored; the fill is not restarted.
- `iClear` and `iWrReq` in the same IDLE writer slot: clear wins, and the write is not acked.
- Colour expansion from RGB332 to 10 bits:
  - R = {R,R,R,R[2]}.
  - G = {G,G,G,G[2]}.
  - B = {B,B,B,B,B}.
  - Output is 0 when the delayed iImValid = 0.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Clear counter 0.
  - Valid delay line 0.
- Scan latency: iX/iY sampled at edge t (iPixEn=1), oRamAddr valid after t, iRamRData valid after t+1, oRed/oGreen/oBlue registered at t+2.
  - That is 2 CLOCK_50 cycles, one pixel clock. Colour holds through the following writer slot.
  - The upstream sync path compensates with a 1-pixel delay.
- Writer handshake:
  - oWrAck is high for exactly one cycle after edge t.
  - The requester must drop or change `iWrReq` by edge t+1, so the next writer slot at t+2 does not repeat the write.
  - Worst-case ack latency in IDLE is 2 cycles.
- Clear duration: FB_W*FB_H writer slots, i.e. 38400 CLOCK_50 cycles at defaults.
- Reset mid-clear aborts immediately; RAM contents are undefined and oBusy=0.

## Test plan
- Reset: assert nRst=0 mid-activity → all outputs 0 asynchronously and state IDLE. After release, the first writer slot with no request gives oRamWe=0.
- Scan expansion: RAM model holds 0xE3 at addr 0; iX=3, iY=2, iImValid=1 at a scan edge → two cycles later oRed=10'h3FF, oGreen=0, oBlue=10'h3FF.
- Scan blanking: same setup but iImValid=0 → oRed/oGreen/oBlue=0.
- Writer handshake: iWrX=159, iWrY=119, iWrData=0x1C in IDLE → a single RAM write at addr 19199 in the next writer slot, oWrAck pulse of exactly 1 cycle, oWrErr=0.
- Out-of-range write: iWrX=160 → ack and oWrErr pulse together with no write.
- Clear: iClear pulse with iClearColor=0x55 and iWrReq held → oBusy high for 38400 cycles and all 19200 addresses written 0x55 in order. The pending request is acked in the first writer slot after oBusy falls. An iClear pulse issued mid-fill does not reset the counter.
- Slot integrity and mid-clear reset:
  - Continuous iWrReq never causes oRamWe=1 in a scan slot.
  - Scan reads continue every scan slot during CLEAR.
  - nRst asserted at counter 1000 → oBusy=0, and a new clear restarts from addr 0.
